// File: rtl/mmult_pkg.sv
// Shared constants and types for the 3x3 matrix multiplier result printer.
// Geometry of the printed dump and the printer FSM encoding.
package mmult_pkg;

  localparam int N = 3;
  localparam int ELEM_W = 18;
  localparam int MAT_W = N * N * ELEM_W;
  localparam int DIGITS = (ELEM_W + 3) / 4;

  localparam int CHARS_PER_ROW = 21;
  localparam int TOTAL_CHARS = 63;

  localparam logic [7:0] LBRACK = 8'h5B;
  localparam logic [7:0] RBRACK = 8'h5D;
  localparam logic [7:0] COMMA = 8'h2C;
  localparam logic [7:0] CR = 8'h0D;
  localparam logic [7:0] LF = 8'h0A;

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

endpackage

// File: rtl/mmult_result_printer_if.sv
// Valid/ready byte stream from the result printer to the UART transmitter.
// The printer is the master; the transmitter is the slave.
interface mmult_result_printer_if;

  logic tx_valid;
  logic tx_ready;
  logic [7:0] tx_data;

  modport master (
    output tx_valid,
    output tx_data,
    input tx_ready
  );

  modport slave (
    input tx_valid,
    input tx_data,
    output tx_ready
  );

endinterface

// File: rtl/mmult_result_printer_hex_ascii.sv
// Nibble to upper-case ASCII hex digit.
// Purely combinational; 0-9 -> '0'-'9', 10-15 -> 'A'-'F'.
module hex_ascii (
  input logic [3:0] nibble,
  output logic [7:0] ascii
);

  always_comb begin
    if (nibble < 4'd10) begin
      ascii = 8'h30 + {4'h0, nibble};
    end else begin
      ascii = 8'h37 + {4'h0, nibble};
    end
  end

endmodule

// File: rtl/mmult_result_printer.sv
// Snapshots the 3x3 result matrix and streams it as 63 ASCII bytes,
// three lines of "[RRRRR,RRRRR,RRRRR]\r\n" over a valid/ready port.
module mmult_result_printer
  import mmult_pkg::*;
(
  input logic clk,
  input logic reset,
  input logic start,
  input logic [0:MAT_W-1] C_mat,
  mmult_result_printer_if.master tx,
  output logic busy,
  output logic done
);

  state_t state;
  logic [0:MAT_W-1] snap;
  logic [5:0] idx;
  logic [1:0] row;
  logic [4:0] pos;
  logic valid_q;
  logic [7:0] data_q;

  logic [4:0] nxt_pos;
  logic [1:0] nxt_row;
  logic [1:0] col;
  logic [2:0] dig;
  logic [ELEM_W-1:0] e0;
  logic [ELEM_W-1:0] e1;
  logic [ELEM_W-1:0] e2;
  logic [ELEM_W-1:0] elem;
  logic [3:0] nib;
  logic [7:0] hex_char;
  logic [7:0] nxt_char;

  logic accept;

  assign tx.tx_valid = valid_q;
  assign tx.tx_data = data_q;
  assign accept = valid_q & tx.tx_ready;

  // {row,pos} track idx so no divide-by-21 is needed
  always_comb begin
    nxt_pos = pos + 5'd1;
    nxt_row = row;
    if (pos == 5'(CHARS_PER_ROW - 1)) begin
      nxt_pos = '0;
      nxt_row = row + 2'd1;
    end
  end

  always_comb begin
    e0 = '0;
    e1 = '0;
    e2 = '0;
    case (nxt_row)
      2'd0: begin
        e0 = snap[0*ELEM_W +: ELEM_W];
        e1 = snap[1*ELEM_W +: ELEM_W];
        e2 = snap[2*ELEM_W +: ELEM_W];
      end
      2'd1: begin
        e0 = snap[3*ELEM_W +: ELEM_W];
        e1 = snap[4*ELEM_W +: ELEM_W];
        e2 = snap[5*ELEM_W +: ELEM_W];
      end
      2'd2: begin
        e0 = snap[6*ELEM_W +: ELEM_W];
        e1 = snap[7*ELEM_W +: ELEM_W];
        e2 = snap[8*ELEM_W +: ELEM_W];
      end
      default: ;
    endcase
  end

  always_comb begin
    col = '0;
    dig = '0;
    unique case (1'b1)
      (nxt_pos >= 5'd1 && nxt_pos <= 5'd5): begin
        col = 2'd0;
        dig = 3'(nxt_pos - 5'd1);
      end
      (nxt_pos >= 5'd7 && nxt_pos <= 5'd11): begin
        col = 2'd1;
        dig = 3'(nxt_pos - 5'd7);
      end
      (nxt_pos >= 5'd13 && nxt_pos <= 5'd17): begin
        col = 2'd2;
        dig = 3'(nxt_pos - 5'd13);
      end
      default: ;
    endcase
  end

  always_comb begin
    case (col)
      2'd1: elem = e1;
      2'd2: elem = e2;
      default: elem = e0;
    endcase
  end

  // Digit 0 carries only the top two bits of the 18-bit element
  always_comb begin
    case (dig)
      3'd0: nib = {2'b00, elem[17:16]};
      3'd1: nib = elem[15:12];
      3'd2: nib = elem[11:8];
      3'd3: nib = elem[7:4];
      default: nib = elem[3:0];
    endcase
  end

  hex_ascii u_hex (
    .nibble(nib),
    .ascii(hex_char)
  );

  always_comb begin
    nxt_char = hex_char;
    unique case (1'b1)
      (nxt_pos == 5'd0): nxt_char = LBRACK;
      (nxt_pos == 5'd6 || nxt_pos == 5'd12): nxt_char = COMMA;
      (nxt_pos == 5'd18): nxt_char = RBRACK;
      (nxt_pos == 5'd19): nxt_char = CR;
      (nxt_pos == 5'd20): nxt_char = LF;
      default: nxt_char = hex_char;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      snap <= '0;
      idx <= '0;
      row <= '0;
      pos <= '0;
      valid_q <= 1'b0;
      data_q <= 8'h00;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            snap <= C_mat;
            idx <= '0;
            row <= '0;
            pos <= '0;
            data_q <= LBRACK;
            valid_q <= 1'b1;
            busy <= 1'b1;
            state <= SEND;
          end
        end
        SEND: begin
          if (accept) begin
            if (idx == 6'(TOTAL_CHARS - 1)) begin
              valid_q <= 1'b0;
              busy <= 1'b0;
              done <= 1'b1;
              state <= IDLE;
            end else begin
              idx <= idx + 6'd1;
              row <= nxt_row;
              pos <= nxt_pos;
              data_q <= nxt_char;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mmult_result_printer.sv
// Directed and randomized checks of the matrix result printer
// against a string-level model of the expected dump.
module tb_mmult_result_printer;

  logic clk = 1'b0;
  logic reset;
  logic start;
  logic [0:161] c_mat;
  logic busy;
  logic done;

  mmult_result_printer_if tx_bus ();

  mmult_result_printer dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .C_mat(c_mat),
    .tx(tx_bus),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int unsigned mat[9];
  int done_cyc;
  bit done_seen;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load();
    for (int i = 0; i < 9; i++) c_mat[18*i +: 18] = 18'(mat[i]);
  endtask

  task automatic set_zero();
    for (int i = 0; i < 9; i++) mat[i] = 0;
  endtask

  // Reference text: one line per row, 5 hex digits per element
  task automatic build();
    int unsigned n;
    int unsigned e;
    exp_q.delete();
    for (int r = 0; r < 3; r++) begin
      exp_q.push_back(8'h5B);
      for (int c = 0; c < 3; c++) begin
        if (c > 0) exp_q.push_back(8'h2C);
        e = mat[3*r + c] & 32'h3FFFF;
        for (int k = 0; k < 5; k++) begin
          n = (e >> (16 - 4*k)) & 15;
          if (n < 10) exp_q.push_back(8'(48 + n));
          else exp_q.push_back(8'(65 + n - 10));
        end
      end
      exp_q.push_back(8'h5D);
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
    end
  endtask

  task automatic begin_dump(input bit hold);
    start = 1'b1;
    step();
    start = hold;
    chk("first_valid", tx_bus.tx_valid, 1);
    chk("first_lbrack", tx_bus.tx_data, 8'h5B);
    chk("first_busy", busy, 1);
  endtask

  // mode 0: ready high, 1: toggle + 5-cycle stall on byte 7, 2: random
  // inject 1: restart + C change at byte 20, 2: reset at byte 30
  task automatic run(input int mode, input int inject);
    int stall;
    bit pv;
    bit pr;
    bit r;
    bit injected;
    logic [7:0] pd;
    stall = 0;
    pv = 0;
    pr = 0;
    r = 0;
    injected = 0;
    pd = 0;
    got_q.delete();
    done_seen = 0;
    done_cyc = -1;
    for (int cyc = 0; cyc < 1000; cyc++) begin
      if (done === 1'b1) begin
        done_seen = 1;
        done_cyc = cyc;
        break;
      end
      if (pv && !pr) begin
        chk("stall_valid", tx_bus.tx_valid, 1);
        chk("stall_data", tx_bus.tx_data, pd);
      end
      case (mode)
        0: r = 1;
        1: begin
          if (got_q.size() == 7 && stall < 5) begin
            r = 0;
            stall++;
          end else begin
            r = (cyc % 2 == 0);
          end
        end
        default: r = 1'($urandom_range(0, 1));
      endcase
      tx_bus.tx_ready = r;
      if (inject == 1) begin
        if (got_q.size() == 20 && !injected) begin
          start = 1'b1;
          for (int i = 0; i < 9; i++) c_mat[18*i +: 18] = 18'd1;
          injected = 1;
        end else begin
          start = 1'b0;
        end
      end
      if (inject == 2 && got_q.size() == 30) begin
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rst_valid", tx_bus.tx_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        return;
      end
      if (tx_bus.tx_valid && r) got_q.push_back(tx_bus.tx_data);
      pv = tx_bus.tx_valid;
      pr = r;
      pd = tx_bus.tx_data;
      step();
    end
  endtask

  task automatic compare(input string tag, input int n);
    chk({tag, "_count"}, got_q.size(), n);
    for (int i = 0; i < n && i < got_q.size(); i++)
      chk($sformatf("%s_b%0d", tag, i), got_q[i], exp_q[i]);
  endtask

  task automatic finish_checks(input string tag, input bit timed);
    chk({tag, "_done_seen"}, done_seen, 1);
    if (timed) chk({tag, "_done_cyc"}, done_cyc, 63);
    chk({tag, "_end_valid"}, tx_bus.tx_valid, 0);
    chk({tag, "_end_busy"}, busy, 0);
    compare(tag, 63);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    c_mat = '0;
    tx_bus.tx_ready = 1'b0;
    step();
    step();
    chk("reset_valid", tx_bus.tx_valid, 0);
    chk("reset_data", tx_bus.tx_data, 8'h00);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    reset = 1'b0;
    step();
    chk("idle_valid", tx_bus.tx_valid, 0);

    // all-zero matrix
    set_zero();
    load();
    build();
    begin_dump(0);
    run(0, 0);
    finish_checks("zero", 1);
    step();
    chk("zero_done_pulse", done, 0);
    chk("zero_idle_valid", tx_bus.tx_valid, 0);

    // diagonal pattern
    set_zero();
    mat[0] = 18'h3FFFF;
    mat[4] = 30;
    mat[8] = 18'h12345;
    load();
    build();
    begin_dump(0);
    run(0, 0);
    finish_checks("diag", 1);
    step();

    // backpressure with a long stall on byte 7
    begin_dump(0);
    run(1, 0);
    finish_checks("bp", 0);
    step();

    // restart request and matrix change mid-dump
    load();
    begin_dump(0);
    run(0, 1);
    start = 1'b0;
    finish_checks("restart", 1);
    step();
    chk("restart_idle", tx_bus.tx_valid, 0);

    // reset mid-dump, then a fresh dump
    load();
    begin_dump(0);
    run(0, 2);
    compare("abort", 30);
    step();
    chk("abort_no_done", done, 0);
    chk("abort_idle", tx_bus.tx_valid, 0);
    begin_dump(0);
    run(0, 0);
    finish_checks("after_rst", 1);
    step();

    // start held high: back-to-back dumps
    begin_dump(1);
    run(0, 0);
    finish_checks("b2b1", 1);
    step();
    chk("b2b_done_low", done, 0);
    chk("b2b_valid", tx_bus.tx_valid, 1);
    chk("b2b_lbrack", tx_bus.tx_data, 8'h5B);
    run(0, 0);
    finish_checks("b2b2", 1);
    start = 1'b0;
    step();
    chk("b2b_stop", tx_bus.tx_valid, 0);

    // random matrices with random backpressure
    for (int t = 0; t < 4; t++) begin
      for (int i = 0; i < 9; i++) mat[i] = $urandom & 32'h3FFFF;
      load();
      build();
      begin_dump(0);
      run(2, 0);
      finish_checks($sformatf("rnd%0d", t), 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
